// File: rtl/fetch_pkg.sv
// Shared widths and types for the byte-granular instruction fetch unit.
// Defaults describe the standard core configuration; modules derive their own widths from parameters.
package fetch_pkg;

    localparam int DEF_WORD        = 8;
    localparam int DEF_FETCH_BYTES = 4;
    localparam int DEF_QDEPTH      = 8;
    localparam int DEF_PC_WIDTH    = 16;
    localparam int DEF_ROM_AW      = 12;

    localparam int LINE_SHIFT = $clog2(DEF_FETCH_BYTES);
    localparam int CNT_W      = $clog2(DEF_QDEPTH) + 1;

    typedef logic [DEF_WORD-1:0]                 byte_t;
    typedef logic [DEF_FETCH_BYTES*DEF_WORD-1:0] line_t;
    typedef logic [DEF_PC_WIDTH-1:0]             pc_t;

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular byte queue: pushes the tail of a ROM line starting at a skip offset,
// pops a variable number of bytes, and presents the head bytes as a peek window.
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter int WORD        = DEF_WORD,
    parameter int FETCH_BYTES = DEF_FETCH_BYTES,
    parameter int QDEPTH      = DEF_QDEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic                            push_i,
    input  logic [FETCH_BYTES*WORD-1:0]     push_data_i,
    input  logic [$clog2(FETCH_BYTES)-1:0]  push_skip_i,
    input  logic                            pop_i,
    input  logic [$clog2(FETCH_BYTES):0]    pop_len_i,
    output logic [FETCH_BYTES*WORD-1:0]     peek_o,
    output logic [$clog2(QDEPTH):0]         count_o
);

    localparam int QAW = $clog2(QDEPTH);
    localparam int CW  = QAW + 1;

    logic [WORD-1:0] mem_q [QDEPTH];
    logic [QAW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   push_n, pop_n;

    assign push_n  = push_i ? (CW'(FETCH_BYTES) - CW'(push_skip_i)) : '0;
    assign pop_n   = pop_i ? CW'(pop_len_i) : '0;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + QAW'(push_n);
            rd_ptr_q <= rd_ptr_q + QAW'(pop_n);
            count_q  <= count_q + push_n - pop_n;
        end
    end

    // Storage needs no reset: bytes beyond count are masked in the peek window.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_BYTES; i++) begin
            if (push_i && (i >= int'(push_skip_i))) begin
                mem_q[wr_ptr_q + QAW'(i - int'(push_skip_i))] <= push_data_i[i*WORD +: WORD];
            end
        end
    end

    always_comb begin
        peek_o = '0;
        for (int i = 0; i < FETCH_BYTES; i++) begin
            if (CW'(i) < count_q) begin
                peek_o[i*WORD +: WORD] = mem_q[rd_ptr_q + QAW'(i)];
            end
        end
    end

endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction fetch/prefetch: issues ROM line reads ahead of the decoder, fills a byte queue,
// and tracks the decode PC through variable-length consumption and branch redirects.
module risc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int WORD        = DEF_WORD,
    parameter int FETCH_BYTES = DEF_FETCH_BYTES,
    parameter int QDEPTH      = DEF_QDEPTH,
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int ROM_AW      = DEF_ROM_AW,
    parameter int RESET_PC    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            rom_en,
    output logic [ROM_AW-1:0]               rom_addr,
    input  logic [FETCH_BYTES*WORD-1:0]     rom_data,
    output logic [FETCH_BYTES*WORD-1:0]     dec_instr,
    input  logic [$clog2(FETCH_BYTES):0]    dec_len,
    output logic                            dec_valid,
    input  logic                            dec_take,
    output logic [PC_WIDTH-1:0]             pc,
    input  logic                            br_en,
    input  logic [PC_WIDTH-1:0]             br_target,
    output logic [$clog2(QDEPTH):0]         q_count
);

    localparam int LS = $clog2(FETCH_BYTES);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int BW = CW + 1;
    localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] LINE_MASK  = ~PC_WIDTH'(FETCH_BYTES - 1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [LS-1:0]       skip_q, skip_d;
    logic                pending_q, pending_d;

    logic [BW-1:0] budget;
    logic          push_en;
    logic          pop_en;

    // Queued bytes plus the in-flight line plus the line about to be requested must fit.
    assign budget    = BW'(q_count) + (pending_q ? BW'(FETCH_BYTES) : '0) + BW'(FETCH_BYTES);
    assign rom_en    = rst && !br_en && (budget <= BW'(QDEPTH));
    assign rom_addr  = fetch_pc_q[ROM_AW+LS-1:LS];
    assign push_en   = pending_q && !br_en;
    assign dec_valid = (q_count != '0) && (q_count >= CW'(dec_len));
    assign pop_en    = dec_take && dec_valid && !br_en;
    assign pc        = pc_q;

    fetch_byte_queue #(
        .WORD        (WORD),
        .FETCH_BYTES (FETCH_BYTES),
        .QDEPTH      (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (br_en),
        .push_i      (push_en),
        .push_data_i (rom_data),
        .push_skip_i (skip_q),
        .pop_i       (pop_en),
        .pop_len_i   (dec_len),
        .peek_o      (dec_instr),
        .count_o     (q_count)
    );

    always_comb begin
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        skip_d     = skip_q;
        pending_d  = rom_en;
        if (br_en) begin
            pc_d       = br_target;
            fetch_pc_d = br_target & LINE_MASK;
            skip_d     = br_target[LS-1:0];
            pending_d  = 1'b0;
        end else begin
            if (rom_en) begin
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(FETCH_BYTES);
            end
            if (push_en) begin
                skip_d = '0;
            end
            if (pop_en) begin
                pc_d = pc_q + PC_WIDTH'(dec_len);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC_V;
            fetch_pc_q <= RESET_PC_V & LINE_MASK;
            skip_q     <= RESET_PC_V[LS-1:0];
            pending_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            skip_q     <= skip_d;
            pending_q  <= pending_d;
        end
    end

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Directed bench for risc_fetch_unit with a 1-cycle-latency ROM model; inputs change and
// outputs are checked around the falling clock edge.
module tb_risc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic [31:0] dec_instr;
    logic [2:0]  dec_len;
    logic        dec_valid;
    logic        dec_take;
    logic [15:0] pc;
    logic        br_en;
    logic [15:0] br_target;
    logic [3:0]  q_count;

    logic [31:0] rom [0:4095];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    risc_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .dec_instr (dec_instr),
        .dec_len   (dec_len),
        .dec_valid (dec_valid),
        .dec_take  (dec_take),
        .pc        (pc),
        .br_en     (br_en),
        .br_target (br_target),
        .q_count   (q_count)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        br_en     = 1'b0;
        br_target = '0;
        dec_take  = 1'b0;
        dec_len   = 3'd1;
        for (int i = 0; i < 4096; i++) rom[i] = 32'hC0C0C0C0 ^ i;
        rom[12'h000] = 32'h04030201;
        rom[12'h041] = 32'hDDCCBBAA;
        rom[12'h042] = 32'h44434241;
        rom[12'h080] = 32'h87868584;
        rom[12'h081] = 32'h1F1E1D1C;
        rom[12'h082] = 32'h2F2E2D2C;
        rom[12'h083] = 32'h3F3E3D3C;

        // reset and initial issue pattern
        step(); step();
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        rst = 1'b1; #1;
        chk("rel_rom_en", 32'(rom_en), 32'd1);
        chk("rel_rom_addr", 32'(rom_addr), 32'h0);
        step();
        chk("c2_rom_en", 32'(rom_en), 32'd1);
        chk("c2_rom_addr", 32'(rom_addr), 32'h1);
        chk("c2_dec_valid", 32'(dec_valid), 32'd0);
        step();
        chk("c3_q_count", 32'(q_count), 32'd4);
        chk("c3_dec_valid", 32'(dec_valid), 32'd1);
        chk("c3_byte0", 32'(dec_instr[7:0]), 32'h01);
        chk("c3_pc", 32'(pc), 32'h0);
        chk("c3_rom_en", 32'(rom_en), 32'd0);
        step();
        chk("c4_q_count_full", 32'(q_count), 32'd8);
        chk("c4_rom_en_stall", 32'(rom_en), 32'd0);

        // variable-length consumption
        rst = 1'b0;
        rom[12'h000] = 32'h44332211;
        rom[12'h001] = 32'h88776655;
        step(); step();
        rst = 1'b1;
        step(); step();
        dec_len = 3'd1; dec_take = 1'b1; #1;
        chk("vl1_valid", 32'(dec_valid), 32'd1);
        chk("vl1_byte0", 32'(dec_instr[7:0]), 32'h11);
        chk("vl1_pc", 32'(pc), 32'h0000);
        step();
        dec_len = 3'd4; #1;
        chk("vl4_pc", 32'(pc), 32'h0001);
        chk("vl4_instr", dec_instr, 32'h55443322);
        chk("vl4_q_count", 32'(q_count), 32'd7);
        chk("vl4_valid", 32'(dec_valid), 32'd1);
        step();
        dec_len = 3'd3; #1;
        chk("vl3_pc", 32'(pc), 32'h0005);
        chk("vl3_instr", dec_instr, 32'h00887766);
        chk("vl3_valid", 32'(dec_valid), 32'd1);
        chk("vl3_rom_addr", 32'(rom_addr), 32'h002);
        step();
        dec_take = 1'b0; dec_len = 3'd1;

        // unaligned branch while a line-2 response is in flight
        br_en = 1'b1; br_target = 16'h0106; #1;
        chk("ub_rom_en_br", 32'(rom_en), 32'd0);
        step();
        br_en = 1'b0; #1;
        chk("ub_pc", 32'(pc), 32'h0106);
        chk("ub_q_count0", 32'(q_count), 32'd0);
        chk("ub_rom_en", 32'(rom_en), 32'd1);
        chk("ub_rom_addr", 32'(rom_addr), 32'h041);
        chk("ub_valid0", 32'(dec_valid), 32'd0);
        step();
        chk("ub_q_count_wait", 32'(q_count), 32'd0);
        chk("ub_rom_addr2", 32'(rom_addr), 32'h042);
        step();
        chk("ub_q_count2", 32'(q_count), 32'd2);
        chk("ub_instr", dec_instr, 32'h0000DDCC);
        chk("ub_valid", 32'(dec_valid), 32'd1);
        chk("ub_rom_en_stall", 32'(rom_en), 32'd0);
        step();
        chk("ub_q_count6", 32'(q_count), 32'd6);
        chk("ub_instr6", dec_instr, 32'h4241DDCC);

        // flush while line 3 is in flight; same-cycle take must be ignored
        rom[12'h002] = 32'h2B2A2928;
        rom[12'h003] = 32'h33333333;
        br_en = 1'b1; br_target = 16'h0008; #1;
        step();
        br_en = 1'b0; #1;
        chk("fl_pc8", 32'(pc), 32'h0008);
        chk("fl_rom_addr2", 32'(rom_addr), 32'h002);
        step();
        chk("fl_rom_addr3", 32'(rom_addr), 32'h003);
        chk("fl_rom_en3", 32'(rom_en), 32'd1);
        step();
        chk("fl_q_count4", 32'(q_count), 32'd4);
        chk("fl_instr_l2", dec_instr, 32'h2B2A2928);
        br_en = 1'b1; br_target = 16'h0200; dec_take = 1'b1; dec_len = 3'd1; #1;
        chk("fl_valid_before", 32'(dec_valid), 32'd1);
        chk("fl_rom_en_br", 32'(rom_en), 32'd0);
        step();
        br_en = 1'b0; dec_take = 1'b0; #1;
        chk("fl_pc", 32'(pc), 32'h0200);
        chk("fl_q_count0", 32'(q_count), 32'd0);
        chk("fl_rom_addr80", 32'(rom_addr), 32'h080);
        step();
        chk("fl_line3_dropped", 32'(q_count), 32'd0);
        chk("fl_rom_addr81", 32'(rom_addr), 32'h081);
        step();
        chk("fl_q_count_new", 32'(q_count), 32'd4);
        chk("fl_instr_l80", dec_instr, 32'h87868584);

        // underflow: two bytes queued, four-byte instruction at the head
        br_en = 1'b1; br_target = 16'h0206; #1;
        step();
        br_en = 1'b0; #1;
        chk("uf_rom_addr81", 32'(rom_addr), 32'h081);
        chk("uf_pc", 32'(pc), 32'h0206);
        step();
        chk("uf_rom_addr82", 32'(rom_addr), 32'h082);
        step();
        dec_len = 3'd4; dec_take = 1'b1; #1;
        chk("uf_q_count2", 32'(q_count), 32'd2);
        chk("uf_valid0", 32'(dec_valid), 32'd0);
        chk("uf_instr", dec_instr, 32'h00001F1E);
        step();
        chk("uf_pc_hold", 32'(pc), 32'h0206);
        chk("uf_q_count_nopop", 32'(q_count), 32'd6);
        chk("uf_valid_rise", 32'(dec_valid), 32'd1);
        chk("uf_instr_full", dec_instr, 32'h2D2C1F1E);
        dec_len = 3'd2; #1;
        step();
        dec_take = 1'b0; #1;
        chk("uf_pc_after", 32'(pc), 32'h0208);
        chk("uf_q_count4", 32'(q_count), 32'd4);
        chk("uf_rom_addr83", 32'(rom_addr), 32'h083);
        chk("uf_instr4", dec_instr, 32'h2F2E2D2C);

        // reset while a response is pending
        step();
        rst = 1'b0; #1;
        chk("mr_rom_en_rst", 32'(rom_en), 32'd0);
        chk("mr_q_count_pre", 32'(q_count), 32'd4);
        step();
        chk("mr_q_count", 32'(q_count), 32'd0);
        chk("mr_pc", 32'(pc), 32'h0000);
        chk("mr_rom_en", 32'(rom_en), 32'd0);
        chk("mr_valid", 32'(dec_valid), 32'd0);
        chk("mr_instr", dec_instr, 32'h0);
        rst = 1'b1; #1;
        chk("mr_rel_rom_en", 32'(rom_en), 32'd1);
        chk("mr_rel_rom_addr", 32'(rom_addr), 32'h000);
        step(); step();
        chk("mr_q_count_l0", 32'(q_count), 32'd4);
        chk("mr_instr_l0", dec_instr, 32'h44332211);
        chk("mr_pc_l0", 32'(pc), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
